// File: rtl/sisc_pkg.sv
// Shared defaults and types for the SISC fetch front end.
package sisc_pkg;

    localparam int SISC_ADDR_W  = 16;
    localparam int SISC_INSTR_W = 32;
    localparam int SISC_DEPTH   = 4;
    localparam logic [SISC_ADDR_W-1:0] SISC_RESET_PC = '0;

    // One prefetched instruction together with the word address it came from.
    typedef struct packed {
        logic [SISC_ADDR_W-1:0]  pc;
        logic [SISC_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Fetch-unit bus: instruction memory request/response, IR port to the
// control unit, and the redirect/halt controls from the branch logic.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The fetch request may be withdrawn before acceptance (halt
// or redirect), the memory tolerates that. The memory response has no ready:
// it arrives in request order and must be taken. ir_data/ir_pc are held
// stable while ir_valid && !ir_ready.
interface sisc_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output ir_valid, ir_data, ir_pc,
        input  ir_ready,
        input  redirect_valid, redirect_pc, halt
    );

    // Memory / control unit / branch logic side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  ir_valid, ir_data, ir_pc,
        output ir_ready,
        output redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/sisc_sync_fifo.sv
// Synchronous FIFO with flush and a registered head output.
// The head register is loaded with the entry that will be at the front after
// this cycle, so a push into an empty queue is visible on the next cycle.
module sisc_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;
    logic             lands_at_head;
    logic [WIDTH-1:0] head_next;

    // Next pointers/occupancy and the value the head register must hold next.
    always_comb begin
        do_push       = push && !flush;
        do_pop        = pop && !flush && (count != '0);
        rd_ptr_next   = rd_ptr + PTR_W'(do_pop);
        count_next    = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        // The incoming entry becomes the head when the queue is (or becomes) empty.
        lands_at_head = do_push && (count == (PTR_W+1)'(do_pop));
        head_next     = lands_at_head ? din : mem[rd_ptr_next];
    end

    // Pointers, occupancy and head register; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            head   <= head_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Entry storage; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // The credit scheme upstream guarantees a push never lands on a full queue.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && count == FULL));

endmodule

// File: rtl/sisc_fetch_unit.sv
// Instruction fetch front end: word-addressed fetch PC, credit-limited
// requests to instruction memory, prefetch queue of {pc, instr} entries,
// and branch redirect with discard of stale in-flight responses.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int ADDR_W  = SISC_ADDR_W,
    parameter int INSTR_W = SISC_INSTR_W,
    parameter int DEPTH   = SISC_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(SISC_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    sisc_fetch_unit_if.master      bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credits_used;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            head_entry;

    // Request gating, handshake decode and queue controls.
    always_comb begin
        // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
        credits_used       = {1'b0, count} + {1'b0, outstanding};
        bus.imem_req_valid = !rst && !bus.halt && !bus.redirect_valid
                             && (credits_used < CREDITS);
        bus.imem_req_addr  = fpc;
        accept             = bus.imem_req_valid && bus.imem_req_ready;
        resp               = bus.imem_resp_valid;
        outstanding_next   = outstanding + CNT_W'(accept) - CNT_W'(resp);
        // Responses owed to a pre-redirect path are dropped, as is any response
        // arriving in the redirect cycle itself.
        push               = resp && !bus.redirect_valid && (discard == '0);
        pop                = bus.ir_valid && bus.ir_ready;
        push_entry         = '{pc: resp_pc, instr: bus.imem_resp_data};
    end

    // Fetch PC, response PC, in-flight count and discard count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc         <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                fpc     <= bus.redirect_pc;
                resp_pc <= bus.redirect_pc;
                // Everything still in flight after this edge belongs to the old path.
                discard <= outstanding_next;
            end else begin
                if (accept) begin
                    fpc <= fpc + 1'b1;
                end
                if (resp) begin
                    if (discard != '0) begin
                        discard <= discard - 1'b1;
                    end else begin
                        resp_pc <= resp_pc + 1'b1;
                    end
                end
            end
        end
    end

    sisc_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (push_entry),
        .head  (head_entry),
        .count (count)
    );

    assign bus.ir_valid = (count != '0);
    assign bus.ir_data  = head_entry.instr;
    assign bus.ir_pc    = head_entry.pc;
    assign fifo_count   = count;
    assign busy         = (outstanding != '0);

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: in-order instruction memory with a
// configurable latency, and a transaction-level model (queue of in-flight
// fetch addresses, queue of prefetched entries) checked every cycle.
module tb_sisc_fetch_unit;
    import sisc_pkg::*;

    localparam int AW    = 16;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [$clog2(DEPTH):0] fifo_count;
    logic                   busy;

    sisc_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    sisc_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    // ---------------- environment / model state ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            stale;
    } infl_t;

    mreq_t         mem_q[$];       // accepted requests awaiting their response
    infl_t         m_inflight[$];  // model: fetches in flight, in order
    fetch_entry_t  exp_q[$];       // model: prefetched entries, head first
    logic [AW-1:0] m_fpc;
    logic [AW-1:0] seen_addr[$];   // accepted request addresses
    logic [AW-1:0] seen_pc[$];     // ir_pc of every consumed instruction

    bit            s_halt;
    bit            s_ir_ready;
    bit            s_req_ready;
    bit            s_redir;
    logic [AW-1:0] s_redir_pc;
    int            mem_lat;
    int            cyc;
    int            n_vec;
    int            n_err;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h0000_1000 + {16'h0000, a};
    endfunction

    function automatic logic [AW-1:0] at_addr(input int i);
        return (i < seen_addr.size()) ? seen_addr[i] : 'x;
    endfunction

    function automatic logic [AW-1:0] at_pc(input int i);
        return (i < seen_pc.size()) ? seen_pc[i] : 'x;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive inputs at the falling edge, compare outputs,
    // advance the model, and return at the following rising edge.
    task automatic step();
        bit            resp;
        bit            e_req;
        bit            e_irv;
        bit            acc;
        bit            pop;
        logic [AW-1:0] resp_addr;
        infl_t         f;
        resp_addr = '0;
        @(negedge clk);
        bus.halt           = s_halt;
        bus.ir_ready       = s_ir_ready;
        bus.imem_req_ready = s_req_ready;
        bus.redirect_valid = s_redir;
        bus.redirect_pc    = s_redir_pc;
        resp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        if (resp) begin
            resp_addr = mem_q[0].addr;
            void'(mem_q.pop_front());
        end
        bus.imem_resp_valid = resp;
        bus.imem_resp_data  = resp ? mem_word(resp_addr) : '0;
        #1;
        e_req = !s_halt && !s_redir && ((exp_q.size() + m_inflight.size()) < DEPTH);
        e_irv = (exp_q.size() != 0);
        chk("req_valid", bus.imem_req_valid, e_req);
        if (e_req) chk("req_addr", bus.imem_req_addr, m_fpc);
        chk("ir_valid", bus.ir_valid, e_irv);
        if (e_irv) begin
            chk("ir_data", bus.ir_data, exp_q[0].instr);
            chk("ir_pc", bus.ir_pc, exp_q[0].pc);
        end
        chk("fifo_count", fifo_count, exp_q.size());
        chk("busy", busy, m_inflight.size() != 0);
        // memory answers whatever the DUT actually had accepted
        if (bus.imem_req_valid && s_req_ready) begin
            mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
            seen_addr.push_back(bus.imem_req_addr);
        end
        if (bus.ir_valid && s_ir_ready && !s_redir) seen_pc.push_back(bus.ir_pc);
        // model update for this edge
        acc = e_req && s_req_ready;
        pop = e_irv && s_ir_ready;
        if (s_redir) begin
            if (resp && m_inflight.size() != 0) void'(m_inflight.pop_front());
            foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
            exp_q.delete();
            m_fpc = s_redir_pc;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (resp && m_inflight.size() != 0) begin
                f = m_inflight.pop_front();
                if (!f.stale) exp_q.push_back('{pc: f.addr, instr: mem_word(f.addr)});
            end
            if (acc) begin
                m_inflight.push_back('{addr: m_fpc, stale: 1'b0});
                m_fpc = m_fpc + 1'b1;
            end
        end
        cyc++;
        @(posedge clk);
    endtask

    // Assert reset between clock edges, check outputs drop at once, then release.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_ir_valid", bus.ir_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", fifo_count, 0);
        s_halt = 0; s_ir_ready = 0; s_req_ready = 0; s_redir = 0; s_redir_pc = '0;
        bus.halt = 0; bus.ir_ready = 0; bus.imem_req_ready = 0;
        bus.redirect_valid = 0; bus.redirect_pc = '0;
        bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
        mem_q.delete(); m_inflight.delete(); exp_q.delete();
        seen_addr.delete(); seen_pc.delete();
        m_fpc = 16'h0000;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        n_vec = 0; n_err = 0; cyc = 0; mem_lat = 1;
        do_reset();

        // Streaming, latency 1, consumer always ready.
        s_req_ready = 1; s_ir_ready = 1; mem_lat = 1;
        step(); step();
        #1;
        chk("stream_first_valid", bus.ir_valid, 1);
        chk("stream_first_data", bus.ir_data, 32'h0000_1000);
        chk("stream_first_pc", bus.ir_pc, 16'h0000);
        repeat (10) step();
        chk("stream_pops", seen_pc.size(), 10);
        for (int i = 0; i < 10; i++) chk("stream_pc_seq", at_pc(i), i);

        // Asynchronous reset in the middle of the stream.
        do_reset();
        s_req_ready = 1; s_ir_ready = 1;
        step();
        chk("rst_resume_addr", at_addr(0), 16'h0000);

        // Backpressure: queue fills to DEPTH, requests stop, then resume at 4.
        do_reset();
        s_req_ready = 1; s_ir_ready = 0; mem_lat = 1;
        repeat (5) step();
        #1;
        chk("bp_fifo_count", fifo_count, 4);
        chk("bp_req_valid", bus.imem_req_valid, 0);
        chk("bp_busy", busy, 0);
        s_ir_ready = 1;
        step();
        #1;
        chk("bp_resume_valid", bus.imem_req_valid, 1);
        chk("bp_resume_addr", bus.imem_req_addr, 16'h0004);
        repeat (10) step();
        chk("bp_enough_pops", seen_pc.size() >= 8, 1);
        for (int i = 0; i < seen_pc.size(); i++) chk("bp_pc_seq", seen_pc[i], i);
        for (int i = 0; i < seen_addr.size(); i++) chk("bp_addr_seq", seen_addr[i], i);

        // Redirect with latency 3, then a back-to-back second redirect.
        do_reset();
        s_req_ready = 1; s_ir_ready = 0; mem_lat = 3;
        repeat (4) step();
        s_redir = 1; s_redir_pc = 16'h0080;
        step();
        #1;
        chk("redir_fifo_count", fifo_count, 0);
        chk("redir_ir_valid", bus.ir_valid, 0);
        chk("redir_busy", busy, 1);
        s_redir_pc = 16'h0040;
        step();
        s_redir = 0; s_ir_ready = 1;
        found = 0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            #1;
            if (bus.ir_valid) found = 1;
        end
        chk("redir_head_seen", found, 1);
        chk("redir_head_data", bus.ir_data, 32'h0000_1040);
        chk("redir_head_pc", bus.ir_pc, 16'h0040);
        repeat (4) step();

        // Address wrap from 0xFFFE.
        do_reset();
        s_req_ready = 1; s_ir_ready = 1; mem_lat = 1;
        s_redir = 1; s_redir_pc = 16'hFFFE;
        step();
        s_redir = 0;
        repeat (6) step();
        chk("wrap_addr0", at_addr(0), 16'hFFFE);
        chk("wrap_addr1", at_addr(1), 16'hFFFF);
        chk("wrap_addr2", at_addr(2), 16'h0000);
        chk("wrap_pc0", at_pc(0), 16'hFFFE);
        chk("wrap_pc1", at_pc(1), 16'hFFFF);
        chk("wrap_pc2", at_pc(2), 16'h0000);

        // Memory not ready for 5 cycles: address held, nothing in flight.
        do_reset();
        s_req_ready = 0; s_ir_ready = 1; mem_lat = 1;
        repeat (5) step();
        #1;
        chk("stall_req_valid", bus.imem_req_valid, 1);
        chk("stall_addr", bus.imem_req_addr, 16'h0000);
        chk("stall_busy", busy, 0);
        s_req_ready = 1;
        repeat (3) step();

        // Halt with two fetches in flight.
        do_reset();
        s_req_ready = 1; s_ir_ready = 1; mem_lat = 2;
        step(); step();
        s_halt = 1;
        repeat (6) step();
        chk("halt_req_count", seen_addr.size(), 2);
        chk("halt_pop_count", seen_pc.size(), 2);
        chk("halt_pc0", at_pc(0), 16'h0000);
        chk("halt_pc1", at_pc(1), 16'h0001);
        chk("halt_busy", busy, 0);
        s_halt = 0;
        repeat (3) step();
        chk("halt_resume_addr", at_addr(2), 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation SISC core. Replaces the fixed PC / IM / IR chain with a word-addressed fetch PC, a valid/ready request port to instruction memory, and a DEPTH-entry prefetch queue of {pc, instr} pairs. Feeds the control unit through a valid/ready IR port, and accepts branch redirects from the branch logic with a flush of all stale fetches.

Parameters:
ADDR_W, 16, fetch address width (word address)
INSTR_W, 32, instruction width
DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_resp_valid  in  1  response valid; in order, no backpressure
imem_resp_data  in  INSTR_W  fetched instruction
ir_valid  out  1  queue head valid
ir_ready  in  1  consumer takes head
ir_data  out  INSTR_W  head instruction
ir_pc  out  ADDR_W  address of head instruction
redirect_valid  in  1  branch taken / flush
redirect_pc  in  ADDR_W  new fetch address
halt  in  1  suppress new requests (level)
fifo_count  out  $clog2(DEPTH)+1  queue occupancy
busy  out  1  outstanding != 0

Behaviour:
- Reset (async, immediate): fpc=RESET_PC, resp_pc=RESET_PC, count=0, outstanding=0, discard=0. imem_req_valid=0, ir_valid=0, busy=0, fifo_count=0. The memory shares rst, so no response arrives for a pre-reset request.
- Request issue: imem_req_valid = !halt && !redirect_valid && (count + outstanding < DEPTH). imem_req_addr = fpc.
- Accept: imem_req_valid && imem_req_ready. On accept, fpc <= fpc+1 (mod 2^ADDR_W) and outstanding +1.
- Requests may be withdrawn before acceptance by halt or redirect. The memory tolerates this.
- Response: outstanding -1. If discard != 0: discard -1 and the data is dropped. Otherwise push {resp_pc, data} and resp_pc <= resp_pc+1 (wraps).
- Credit rule: count + outstanding <= DEPTH always, so a push never overflows. An overflow is an assertion error.
- Pop: ir_valid && ir_ready. ir_valid = (count != 0). ir_data and ir_pc are registered queue-head outputs, stable while ir_valid && !ir_ready.
- Simultaneous push and pop: count unchanged. A push into an empty queue makes the entry visible the next cycle (1-cycle response-to-IR latency).
- Redirect (highest priority), at the edge after redirect_valid=1:
  - queue cleared (count=0); a pop in the same cycle is ignored;
  - fpc <= redirect_pc and resp_pc <= redirect_pc;
  - discard <= outstanding after this cycle's updates; a response arriving in the redirect cycle is dropped;
  - no request is issued in the redirect cycle.
- Back-to-back redirects: the later one wins; discard is recomputed each time.
- Halt: new requests stop; in-flight responses are still queued; the queue still drains. Deasserting halt resumes at fpc.
- Wrap: fpc and resp_pc roll over from 2^ADDR_W-1 to 0 with no flag.
- busy = (outstanding != 0). fifo_count = count.

Decomposition:
- sisc_pkg: ADDR_W/INSTR_W defaults, RESET_PC default, and a typedef for the {pc, instr} fetch entry.
- One sub-module: sisc_sync_fifo (parametrised WIDTH/DEPTH, async active-high rst, push/pop/flush, count output, registered head). It holds the {pc, instr} entries.
- Counters and redirect/discard logic stay in sisc_fetch_unit.

Test Plan:
- Streaming: reset, then memory with 1-cycle latency, mem[a]=0x1000+a, ir_ready=1, DEPTH=4 -> requests at addr 0,1,2,… each cycle; first ir_data=0x00001000 with ir_pc=0x0000; then one instruction per cycle, ir_pc incrementing.
- Backpressure: ir_ready=0 -> after 4 responses fifo_count=4 and imem_req_valid=0; raise ir_ready -> requests resume at addr 0x0004, no loss or duplicate.
- Redirect with latency 3 and 2 outstanding: redirect_pc=0x0040 -> queue empty next cycle; the 2 stale responses are dropped; next ir_data=mem[0x40] with ir_pc=0x0040.
- Wrap: RESET_PC=0xFFFE -> request addresses FFFE, FFFF, 0000; ir_pc follows the same sequence.
- Stall/halt:
  - imem_req_ready=0 for 5 cycles -> addr held at fpc, outstanding=0.
  - halt=1 with 2 in flight -> both are queued, then no new requests; halt=0 resumes at the next address.
- Async reset mid-stream: assert rst between edges -> imem_req_valid, ir_valid, busy go 0 immediately; on release, the first request is RESET_PC.
